map_mem_arbiter: RTL and testbench
==================================

Name: map_mem_arbiter

Overview:
- N-reader, 1-writer arbiter in front of the single-port tile-map memory (NUM_ROW x NUM_COL entries, MAP_MEM_WIDTH bits each).
- Generalises the two-reader map read controller to NUM_READERS readers, using round-robin grants.
- Adds a priority write channel for bomb placement and block destruction, bounded so that writes cannot starve reads.
- Returns read data with a per-reader valid strobe, aligned to the memory's latency.

Parameters:
- NUM_ROW, 11, map rows
- NUM_COL, 19, map columns
- MAP_MEM_WIDTH, 2, bits per tile entry
- NUM_READERS, 4, read requesters (2..8)
- MEM_LATENCY, 1, cycles from mem_addr/mem_re to mem_rdata valid (1..3)
- WR_BURST_MAX, 4, maximum consecutive write grants while any read is pending
- Derived: DEPTH = NUM_ROW*NUM_COL; ADDR_WIDTH = $clog2(DEPTH)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- read_req  in  NUM_READERS  per-reader request level; held until granted
- read_addr_req  in  ADDR_WIDTH x [0:NUM_READERS-1]  per-reader address
- read_granted  out  NUM_READERS  one-hot grant pulse, one cycle
- rd_data  out  MAP_MEM_WIDTH  returned tile data, shared by all readers
- rd_valid  out  NUM_READERS  one-hot; rd_data belongs to this reader this cycle
- wr_req  in  1  write request level; held until granted
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  MAP_MEM_WIDTH  write data
- wr_granted  out  1  write grant pulse, one cycle
- mem_addr  out  ADDR_WIDTH  memory address
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_wdata  out  MAP_MEM_WIDTH  memory write data
- mem_rdata  in  MAP_MEM_WIDTH  memory read data

Behaviour:
- Reset state: every output is 0, the valid pipeline is cleared, rr_ptr = NUM_READERS-1 (reader 0 wins first), and wr_burst_cnt = 0.
- A reset asserted mid-operation drops all in-flight reads; no rd_valid is emitted for them.
- Arbitration is evaluated combinationally in cycle T from read_req, wr_req, rr_ptr and wr_burst_cnt. Result registers update at the edge ending T.
- Write wins when wr_req=1 and (no read pending, or wr_burst_cnt < WR_BURST_MAX).
- Otherwise a read wins. The read winner is the first requesting index scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_READERS.
- Cycle T+1 after a read grant to reader i:
  - read_granted[i]=1 and mem_re=1;
  - mem_addr = read_addr_req[i] as sampled in T;
  - rr_ptr = i.
- Cycle T+1 after a write grant:
  - wr_granted=1 and mem_we=1;
  - mem_addr = wr_addr, mem_wdata = wr_data;
  - rr_ptr is unchanged.
- mem_re and mem_we are never both 1. On idle cycles all grant and enable outputs are 0, and mem_addr holds its last value.
- wr_burst_cnt:
  - increments on each write grant made while any read_req is pending (saturates at WR_BURST_MAX);
  - clears on any read grant, and on a write grant with no read pending.
  - With the defaults, at most 4 consecutive writes occur before a waiting read is served.
- Requesters must not count a grant until read_granted/wr_granted is seen. A requester holding its request after the grant cycle issues a new request.
- A requester may deassert before being granted; it is then simply not granted, and no error is raised.
- Read return:
  - a one-hot valid shift register of depth MEM_LATENCY records the reader index of each read grant;
  - in cycle T+1+MEM_LATENCY, rd_valid[i]=1 and rd_data = mem_rdata, passed combinationally;
  - rd_data = 0 when no rd_valid bit is set.
- Throughput is one access per cycle. Back-to-back reads to different readers return in grant order.
- A write to address A granted after a read of A does not affect that read's data. Read-during-write ordering is that of the memory itself; the arbiter does no forwarding.
- Addresses >= DEPTH are passed through unchecked; the memory wrapper owns range checking.

Test Plan:
- Reset, then reader 0 holds read_req=4'b0001 with addr 10 → read_granted=4'b0001 one cycle later, mem_re=1, mem_addr=10; with MEM_LATENCY=1, rd_valid=4'b0001 the following cycle with rd_data=mem_rdata.
- All four readers request continuously (addr 30/40/50/60) → grants rotate 0,1,2,3,0,...; mem_addr sequence is 30,40,50,60,30; no grant is repeated before all four are served.
- wr_req held with addr 100, data 2'b11, and reader 2 pending → 4 write grants (mem_we=1, mem_wdata=3), then read_granted[2], then writes resume; mem_re and mem_we are never both high.
- Reader 1 is granted at addr 20, then rst is asserted the next cycle → all outputs 0, no rd_valid for reader 1, rr_ptr restored so reader 0 is served first after release.
- With MEM_LATENCY=3, readers 3 then 0 are granted back to back → rd_valid=4'b1000 then 4'b0001, three cycles after their respective grants, with data matching mem_rdata each cycle.
- read_req[1] is pulsed for one cycle while reader 0 is being granted → reader 1 is never granted, and no spurious rd_valid[1] appears.

Source files
------------

// File: rtl/map_mem_arbiter.sv
// map_mem_arbiter: round-robin N-reader / bounded-priority single-writer arbiter for the tile-map memory
module map_mem_arbiter #(
  parameter int NUM_ROW = 11,
  parameter int NUM_COL = 19,
  parameter int MAP_MEM_WIDTH = 2,
  parameter int NUM_READERS = 4,
  parameter int MEM_LATENCY = 1,
  parameter int WR_BURST_MAX = 4,
  localparam int DEPTH = NUM_ROW * NUM_COL,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_READERS-1:0]   read_req,
  input  logic [ADDR_WIDTH-1:0]    read_addr_req [NUM_READERS],
  output logic [NUM_READERS-1:0]   read_granted,
  output logic [MAP_MEM_WIDTH-1:0] rd_data,
  output logic [NUM_READERS-1:0]   rd_valid,
  input  logic                     wr_req,
  input  logic [ADDR_WIDTH-1:0]    wr_addr,
  input  logic [MAP_MEM_WIDTH-1:0] wr_data,
  output logic                     wr_granted,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic                     mem_re,
  output logic                     mem_we,
  output logic [MAP_MEM_WIDTH-1:0] mem_wdata,
  input  logic [MAP_MEM_WIDTH-1:0] mem_rdata
);
  localparam int IDX_W = $clog2(NUM_READERS);
  localparam int CNT_W = $clog2(WR_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(WR_BURST_MAX);
  logic [NUM_READERS-1:0]   r_read_granted;
  logic                     r_wr_granted;
  logic [ADDR_WIDTH-1:0]    r_mem_addr;
  logic                     r_mem_re;
  logic                     r_mem_we;
  logic [MAP_MEM_WIDTH-1:0] r_mem_wdata;
  logic [IDX_W-1:0]         r_rr_ptr;
  logic [CNT_W-1:0]         r_burst;
  logic [NUM_READERS-1:0]   r_vpipe [MEM_LATENCY];
  logic [IDX_W-1:0]         w_cand [NUM_READERS];
  logic                     w_rd_pend;
  logic                     w_wr_win;
  logic                     w_rd_win;
  logic [IDX_W-1:0]         w_rd_idx;
  assign w_rd_pend = |read_req;
  assign w_wr_win  = wr_req && (!w_rd_pend || r_burst < BURST_MAX);
  // scan backwards so the candidate nearest rr_ptr+1 is the one that sticks
  always_comb begin
    w_rd_win = 1'b0;
    w_rd_idx = '0;
    for (int k = 0; k < NUM_READERS; k++) w_cand[k] = IDX_W'((int'(r_rr_ptr) + k + 1) % NUM_READERS);
    for (int k = NUM_READERS - 1; k >= 0; k--) begin
      if (read_req[w_cand[k]]) begin
        w_rd_win = 1'b1;
        w_rd_idx = w_cand[k];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_granted <= '0;
      r_wr_granted   <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_re       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_wdata    <= '0;
      r_rr_ptr       <= IDX_W'(NUM_READERS - 1);
      r_burst        <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) r_vpipe[i] <= '0;
    end else begin
      r_read_granted <= '0;
      r_wr_granted   <= 1'b0;
      r_mem_re       <= 1'b0;
      r_mem_we       <= 1'b0;
      if (w_wr_win) begin
        r_wr_granted <= 1'b1;
        r_mem_we     <= 1'b1;
        r_mem_addr   <= wr_addr;
        r_mem_wdata  <= wr_data;
        r_burst      <= w_rd_pend ? r_burst + 1'b1 : '0;
      end else if (w_rd_win) begin
        r_read_granted <= NUM_READERS'(1) << w_rd_idx;
        r_mem_re       <= 1'b1;
        r_mem_addr     <= read_addr_req[w_rd_idx];
        r_rr_ptr       <= w_rd_idx;
        r_burst        <= '0;
      end
      r_vpipe[0] <= r_read_granted;
      for (int i = 1; i < MEM_LATENCY; i++) r_vpipe[i] <= r_vpipe[i-1];
    end
  end
  assign read_granted = r_read_granted;
  assign wr_granted   = r_wr_granted;
  assign mem_addr     = r_mem_addr;
  assign mem_re       = r_mem_re;
  assign mem_we       = r_mem_we;
  assign mem_wdata    = r_mem_wdata;
  assign rd_valid     = r_vpipe[MEM_LATENCY-1];
  assign rd_data      = |rd_valid ? mem_rdata : '0;
endmodule

// File: tb/tb_map_mem_arbiter.sv
// tb_map_mem_arbiter: directed checks of arbitration, write bursting, reset and read return at latency 1 and 3
module tb_map_mem_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] read_req;
  logic [7:0] raddr [4];
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [1:0] wr_data;
  logic [1:0] mem_rdata;
  logic [3:0] gnt1, vld1, gnt3, vld3;
  logic [1:0] rdat1, rdat3, wdat1, wdat3;
  logic       wg1, wg3, re1, re3, we1, we3;
  logic [7:0] ma1, ma3;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  map_mem_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .read_req(read_req), .read_addr_req(raddr), .read_granted(gnt1),
    .rd_data(rdat1), .rd_valid(vld1), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_granted(wg1), .mem_addr(ma1), .mem_re(re1), .mem_we(we1), .mem_wdata(wdat1),
    .mem_rdata(mem_rdata));
  map_mem_arbiter #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .read_req(read_req), .read_addr_req(raddr), .read_granted(gnt3),
    .rd_data(rdat3), .rd_valid(vld3), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_granted(wg3), .mem_addr(ma3), .mem_re(re3), .mem_we(we3), .mem_wdata(wdat3),
    .mem_rdata(mem_rdata));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1; read_req = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; mem_rdata = '0;
    for (int i = 0; i < 4; i++) raddr[i] = '0;
    tick(); tick();
    chk("rst_gnt", {gnt1, wg1, re1, we1}, 0);
    chk("rst_addr", {ma1, wdat1}, 0);
    chk("rst_vld", {vld1, rdat1}, 0);
    rst = 1'b0;
    // single read from reader 0
    read_req = 4'b0001; raddr[0] = 8'd10;
    tick();
    chk("r0_gnt", gnt1, 4'b0001);
    chk("r0_re_addr", {re1, we1, ma1}, {2'b10, 8'd10});
    read_req = '0; mem_rdata = 2'b10;
    tick();
    chk("r0_vld", vld1, 4'b0001);
    chk("r0_data", rdat1, 2'b10);
    chk("idle_hold", {gnt1, re1, ma1}, {5'b00000, 8'd10});
    // round robin with all readers requesting
    rst = 1'b1; tick(); rst = 1'b0;
    raddr[0] = 8'd30; raddr[1] = 8'd40; raddr[2] = 8'd50; raddr[3] = 8'd60;
    read_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_gnt", gnt1, 4'b0001 << (k % 4));
      chk("rr_addr", ma1, 8'd30 + 8'd10 * 8'(k % 4));
      if (k > 0) chk("rr_vld", vld1, 4'b0001 << (k - 1));
    end
    read_req = '0;
    // write burst against pending reader 2 (rr_ptr now 0)
    wr_req = 1'b1; wr_addr = 8'd100; wr_data = 2'b11; raddr[2] = 8'd70; read_req = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("wb_wr", {wg1, we1, re1, gnt1}, {3'b110, 4'b0000});
      chk("wb_addr", {ma1, wdat1}, {8'd100, 2'b11});
    end
    tick();
    chk("wb_rd", {gnt1, re1, we1, wg1}, {4'b0100, 3'b100});
    chk("wb_rd_addr", ma1, 8'd70);
    read_req = '0; mem_rdata = 2'b01;
    tick();
    chk("wb_resume", {wg1, we1, re1}, 3'b110);
    chk("wb_vld", {vld1, rdat1}, {4'b0100, 2'b01});
    tick();
    chk("wb_free", {wg1, we1, re1}, 3'b110);
    wr_req = 1'b0;
    tick();
    chk("wb_idle", {wg1, we1, re1, gnt1}, 0);
    // reset with a read in flight (rr_ptr now 2)
    raddr[1] = 8'd20; read_req = 4'b0010;
    tick();
    chk("rs_gnt", {gnt1, ma1}, {4'b0010, 8'd20});
    rst = 1'b1; read_req = '0; mem_rdata = 2'b11;
    tick();
    chk("rs_outs", {gnt1, wg1, re1, we1, ma1, wdat1}, 0);
    chk("rs_vld", {vld1, rdat1}, 0);
    rst = 1'b0; raddr[0] = 8'd5; read_req = 4'b0011;
    tick();
    chk("rs_first", gnt1, 4'b0001);
    read_req = 4'b0010;
    tick();
    chk("rs_second", {gnt1, vld1}, {4'b0010, 4'b0001});
    read_req = '0;
    tick();
    // one-cycle pulse on reader 1 while reader 0 wins (rr_ptr 1 -> scan 2,3,0,1)
    read_req = 4'b0011;
    tick();
    chk("pl_gnt", gnt1, 4'b0001);
    read_req = '0;
    tick();
    chk("pl_nogrant", {gnt1, vld1}, {4'b0000, 4'b0001});
    tick();
    chk("pl_novld", {gnt1, vld1, rdat1}, 0);
    // latency 3 instance: readers 3 then 0 back to back
    rst = 1'b1; tick(); rst = 1'b0;
    raddr[3] = 8'd60; raddr[0] = 8'd30; read_req = 4'b1000;
    tick();
    chk("l3_gnt3", {gnt3, ma3}, {4'b1000, 8'd60});
    read_req = 4'b0001;
    tick();
    chk("l3_gnt0", {gnt3, ma3}, {4'b0001, 8'd30});
    read_req = '0; mem_rdata = 2'b11;
    tick();
    chk("l3_early", {vld3, rdat3}, 0);
    mem_rdata = 2'b01;
    tick();
    chk("l3_vld3", {vld3, rdat3}, {4'b1000, 2'b01});
    mem_rdata = 2'b10;
    tick();
    chk("l3_vld0", {vld3, rdat3}, {4'b0001, 2'b10});
    tick();
    chk("l3_done", {vld3, rdat3}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
